// File: rtl/sevenseg_pkg.sv
// Shared types, constants and helpers for the multiplexed seven-segment controller.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    LIT   = 2'd1,
    DARK  = 2'd2
  } slot_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high {a..g} glyphs for hex digits 0..F.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Lit portion of a digit slot for a brightness level, capped to the non-blank part.
  function automatic logic [31:0] calc_lit_len(
    input logic [31:0] bright,
    input int unsigned digit_ticks,
    input int unsigned blank_ticks,
    input int unsigned bright_w
  );
    logic [63:0] scaled;
    logic [63:0] cap;
    scaled = ((64'(bright) + 64'd1) * 64'(digit_ticks)) >> bright_w;
    cap    = 64'(digit_ticks - blank_ticks);
    return (scaled < cap) ? 32'(scaled) : 32'(cap);
  endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex nibble to active-high {a..g} segment lookup.
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs_c
);

  // Font table lookup.
  assign segs_c = HEX_FONT[nibble];

endmodule

// File: rtl/sevenseg_mux_ctrl.sv
// N-digit multiplexed seven-segment controller with shadow/display register tiers,
// per-digit enable, hex/raw modes, PWM brightness and anti-ghost blanking.
module sevenseg_mux_ctrl
  import sevenseg_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned REFRESH_HZ  = 1000,
  parameter int unsigned BRIGHT_W    = 3,
  parameter int unsigned BLANK_TICKS = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_update,
  input  logic [4*N_DIGITS-1:0]   i_digits,
  input  logic [7*N_DIGITS-1:0]   i_raw_segs,
  input  logic                    i_raw_mode,
  input  logic [N_DIGITS-1:0]     i_dig_en,
  input  logic [N_DIGITS-1:0]     i_dp,
  input  logic [BRIGHT_W-1:0]     i_brightness,
  output logic [N_DIGITS-1:0]     o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame_start
);

  localparam int unsigned DIGIT_TICKS = CLK_FREQ_HZ / (REFRESH_HZ * N_DIGITS);
  localparam int unsigned TICK_W      = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int unsigned IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

  // Parameter sanity: slot must hold the blanking interval plus at least one tick.
  if (N_DIGITS < 1 || N_DIGITS > 16) begin : g_bad_digits
    $error("sevenseg_mux_ctrl: N_DIGITS must be 1..16");
  end
  if (BLANK_TICKS < 1) begin : g_bad_blank
    $error("sevenseg_mux_ctrl: BLANK_TICKS must be at least 1");
  end
  if (DIGIT_TICKS < BLANK_TICKS + 1) begin : g_bad_ticks
    $error("sevenseg_mux_ctrl: DIGIT_TICKS must exceed BLANK_TICKS");
  end

  // Shadow tier (written by software) and display tier (used by the scan).
  logic [N_DIGITS-1:0][3:0] sh_digits, ds_digits;
  logic [N_DIGITS-1:0][6:0] sh_raw,    ds_raw;
  logic                     sh_raw_mode, ds_raw_mode;
  logic [N_DIGITS-1:0]      sh_en,     ds_en;
  logic [N_DIGITS-1:0]      sh_dp,     ds_dp;
  logic [BRIGHT_W-1:0]      sh_bright, ds_bright;

  logic [TICK_W-1:0] tick_cnt;
  logic [IDX_W-1:0]  dig_idx;
  slot_state_e       state;

  logic        slot_last;
  logic        frame_wrap;
  logic [31:0] lit_len;
  logic [31:0] tick_inc;
  logic [6:0]  hex_segs_c;
  logic [6:0]  seg_sel_c;
  logic        drive_c;

  assign slot_last  = (tick_cnt == TICK_LAST);
  assign frame_wrap = slot_last && (dig_idx == IDX_LAST);
  assign lit_len    = calc_lit_len(32'(ds_bright), DIGIT_TICKS, BLANK_TICKS, BRIGHT_W);
  assign tick_inc   = 32'(tick_cnt) + 32'd1;

  // Glyph for the digit currently being scanned.
  sevenseg_hex_decode u_hex_decode (
    .nibble (ds_digits[dig_idx]),
    .segs_c (hex_segs_c)
  );

  assign seg_sel_c = ds_raw_mode ? ds_raw[dig_idx] : hex_segs_c;
  assign drive_c   = (state == LIT) && ds_en[dig_idx];

  // Shadow tier capture on update strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_digits   <= '0;
      sh_raw      <= '0;
      sh_raw_mode <= 1'b0;
      sh_en       <= '0;
      sh_dp       <= '0;
      sh_bright   <= '0;
    end else if (i_update) begin
      sh_digits   <= i_digits;
      sh_raw      <= i_raw_segs;
      sh_raw_mode <= i_raw_mode;
      sh_en       <= i_dig_en;
      sh_dp       <= i_dp;
      sh_bright   <= i_brightness;
    end
  end

  // Display tier follows the shadow tier only at frame wrap, so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      ds_digits   <= '0;
      ds_raw      <= '0;
      ds_raw_mode <= 1'b0;
      ds_en       <= '0;
      ds_dp       <= '0;
      ds_bright   <= '0;
    end else if (frame_wrap) begin
      ds_digits   <= sh_digits;
      ds_raw      <= sh_raw;
      ds_raw_mode <= sh_raw_mode;
      ds_en       <= sh_en;
      ds_dp       <= sh_dp;
      ds_bright   <= sh_bright;
    end
  end

  // Slot timer, digit index and per-slot BLANK/LIT/DARK sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      dig_idx  <= '0;
      state    <= BLANK;
    end else if (slot_last) begin
      tick_cnt <= '0;
      dig_idx  <= (dig_idx == IDX_LAST) ? '0 : dig_idx + IDX_W'(1);
      state    <= BLANK;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
      case (state)
        BLANK:   if (tick_inc == BLANK_TICKS) state <= (lit_len != 32'd0) ? LIT : DARK;
        LIT:     if (tick_inc == BLANK_TICKS + lit_len) state <= DARK;
        DARK:    state <= DARK;
        default: state <= BLANK;
      endcase
    end
  end

  // Registered pad drivers: one-cycle view of the scan state.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_an          <= '1;
      o_seg         <= SEG_OFF;
      o_dp          <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= (tick_cnt == '0) && (dig_idx == '0);
      if (drive_c) begin
        o_an  <= ~(N_DIGITS'(1) << dig_idx);
        o_seg <= ~seg_sel_c;
        o_dp  <= ~ds_dp[dig_idx];
      end else begin
        o_an  <= '1;
        o_seg <= SEG_OFF;
        o_dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_mux_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a frame-position model.
module tb_sevenseg_mux_ctrl;

  localparam int N     = 4;
  localparam int DT    = 8;
  localparam int BLK   = 1;
  localparam int BW    = 3;
  localparam int FRAME = N * DT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_update = 1'b0;
  logic [15:0] i_digits = '0;
  logic [27:0] i_raw_segs = '0;
  logic        i_raw_mode = 1'b0;
  logic [3:0]  i_dig_en = '0;
  logic [3:0]  i_dp = '0;
  logic [2:0]  i_brightness = '0;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame_start;

  int n_cmp = 0;
  int n_mis = 0;

  logic [6:0] FONT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Model: position within the frame plus the two register tiers.
  int          pos = 0;
  logic [15:0] sh_dig = '0, ds_dig = '0;
  logic [27:0] sh_raw = '0, ds_raw = '0;
  logic        sh_rm = 1'b0, ds_rm = 1'b0;
  logic [3:0]  sh_en = '0, ds_en = '0, sh_dp = '0, ds_dp = '0;
  logic [2:0]  sh_b = '0, ds_b = '0;

  always #5 clk = ~clk;

  sevenseg_mux_ctrl #(
    .N_DIGITS    (N),
    .CLK_FREQ_HZ (800),
    .REFRESH_HZ  (25),
    .BRIGHT_W    (BW),
    .BLANK_TICKS (BLK)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_update      (i_update),
    .i_digits      (i_digits),
    .i_raw_segs    (i_raw_segs),
    .i_raw_mode    (i_raw_mode),
    .i_dig_en      (i_dig_en),
    .i_dp          (i_dp),
    .i_brightness  (i_brightness),
    .o_an          (o_an),
    .o_seg         (o_seg),
    .o_dp          (o_dp),
    .o_frame_start (o_frame_start)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict registered outputs from the pre-edge model, advance the model, compare.
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic [6:0] glyph;
    logic       e_dp;
    logic       e_fs;
    int idx, tick, ll;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
    if (!rst) begin
      idx  = pos / DT;
      tick = pos % DT;
      ll   = ((int'(ds_b) + 1) * DT) >> BW;
      if (ll > DT - BLK) ll = DT - BLK;
      e_fs  = (pos == 0);
      glyph = ds_rm ? ds_raw[idx*7 +: 7] : FONT[ds_dig[idx*4 +: 4]];
      if (tick >= BLK && tick < BLK + ll && ds_en[idx]) begin
        e_an  = ~(4'b0001 << idx);
        e_seg = ~glyph;
        e_dp  = ~ds_dp[idx];
      end
    end
    if (rst) begin
      pos = 0;
      sh_dig = '0; ds_dig = '0; sh_raw = '0; ds_raw = '0; sh_rm = 1'b0; ds_rm = 1'b0;
      sh_en = '0; ds_en = '0; sh_dp = '0; ds_dp = '0; sh_b = '0; ds_b = '0;
    end else begin
      if (pos == FRAME - 1) begin
        ds_dig = sh_dig; ds_raw = sh_raw; ds_rm = sh_rm;
        ds_en = sh_en; ds_dp = sh_dp; ds_b = sh_b;
      end
      if (i_update) begin
        sh_dig = i_digits; sh_raw = i_raw_segs; sh_rm = i_raw_mode;
        sh_en = i_dig_en; sh_dp = i_dp; sh_b = i_brightness;
      end
      pos = (pos + 1) % FRAME;
    end
    @(posedge clk);
    #1;
    check("o_an", 32'(o_an), 32'(e_an));
    check("o_seg", 32'(o_seg), 32'(e_seg));
    check("o_dp", 32'(o_dp), 32'(e_dp));
    check("o_frame_start", 32'(o_frame_start), 32'(e_fs));
  endtask

  task automatic pulse_update();
    i_update = 1'b1;
    step();
    i_update = 1'b0;
  endtask

  // Advance until the frame_start pulse is observed, bounded.
  task automatic wait_frame(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      step();
      if (o_frame_start === 1'b1) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // Step until the last observed output corresponds to frame position k.
  task automatic goto_out(input int k);
    for (int i = 0; i < FRAME && pos != (k + 1) % FRAME; i++) step();
  endtask

  initial begin
    int cnt, bad;

    // Reset
    rst = 1'b1;
    repeat (3) step();
    check("reset_an", 32'(o_an), 32'hF);
    check("reset_seg", 32'(o_seg), 32'h7F);
    check("reset_dp", 32'(o_dp), 32'd1);
    check("reset_fs", 32'(o_frame_start), 32'd0);
    rst = 1'b0;
    cnt = 0;
    repeat (FRAME + 5) begin
      step();
      if (o_an !== 4'hF) cnt++;
    end
    check("idle_anode_activity", 32'(cnt), 32'd0);

    // Hex display at full brightness
    i_digits = 16'h8F10; i_dig_en = 4'hF; i_brightness = 3'd7; i_raw_mode = 1'b0; i_dp = 4'h0;
    pulse_update();
    wait_frame("hex_frame_timeout");
    cnt = (o_an == 4'b1110) ? 1 : 0;
    for (int k = 1; k < FRAME; k++) begin
      step();
      if (k < DT && o_an == 4'b1110) cnt++;
      if (k == 1)  begin check("hex_slot0_an", 32'(o_an), 32'hE); check("hex_slot0_seg", 32'(o_seg), 32'h01); end
      if (k == 9)  check("hex_slot1_seg", 32'(o_seg), 32'h4F);
      if (k == 17) check("hex_slot2_seg", 32'(o_seg), 32'h38);
      if (k == 25) check("hex_slot3_seg", 32'(o_seg), 32'h00);
    end
    check("hex_slot0_lit_cycles", 32'(cnt), 32'd7);

    // Brightness 1 then 0
    i_brightness = 3'd1;
    pulse_update();
    wait_frame("b1_frame_timeout");
    cnt = 0;
    repeat (FRAME - 1) begin step(); if (o_an != 4'hF) cnt++; end
    check("b1_lit_cycles_per_frame", 32'(cnt), 32'd8);
    i_brightness = 3'd0;
    pulse_update();
    wait_frame("b0_frame_timeout");
    cnt = 0;
    repeat (FRAME - 1) begin step(); if (o_an != 4'hF) cnt++; end
    check("b0_lit_cycles_per_frame", 32'(cnt), 32'd4);

    // Raw mode with a single enabled digit
    i_raw_mode = 1'b1; i_raw_segs = 28'($urandom); i_raw_segs[20:14] = 7'h55;
    i_dig_en = 4'b0100; i_dp = 4'b0100; i_brightness = 3'd7;
    pulse_update();
    wait_frame("raw_frame_timeout");
    cnt = 0; bad = 0;
    repeat (FRAME - 1) begin
      step();
      if (o_an == 4'b1011) begin
        cnt++;
        if (o_seg != 7'h2A || o_dp != 1'b0) bad++;
      end else if (o_an != 4'hF || o_seg != 7'h7F || o_dp != 1'b1) bad++;
    end
    check("raw_digit2_lit_cycles", 32'(cnt), 32'd7);
    check("raw_other_activity", 32'(bad), 32'd0);

    // Tear-free update mid-frame
    i_raw_mode = 1'b0; i_digits = 16'hC450; i_dig_en = 4'hF; i_dp = 4'h0;
    pulse_update();
    wait_frame("tear_frame_timeout");
    goto_out(11);
    i_digits = 16'h0001;
    pulse_update();
    goto_out(17);
    check("tear_old_slot2", 32'(o_seg), 32'h4C);
    goto_out(25);
    check("tear_old_slot3", 32'(o_seg), 32'h31);
    wait_frame("tear_next_timeout");
    step();
    check("tear_new_slot0", 32'(o_seg), 32'h4F);
    goto_out(17);
    check("tear_new_slot2", 32'(o_seg), 32'h01);

    // Update coinciding with frame wrap
    i_digits = 16'h0002;
    pulse_update();
    goto_out(30);
    i_digits = 16'h0003;
    pulse_update();
    wait_frame("wrap_fs1_timeout");
    step();
    check("wrap_old_data", 32'(o_seg), 32'h12);
    wait_frame("wrap_fs2_timeout");
    step();
    check("wrap_new_data", 32'(o_seg), 32'h06);

    // Reset asserted during LIT
    wait_frame("rst_frame_timeout");
    repeat (3) step();
    check("rst_pre_lit_an", 32'(o_an), 32'hE);
    rst = 1'b1;
    step();
    check("rst_mid_lit_an", 32'(o_an), 32'hF);
    rst = 1'b0;
    step();

    // Randomized traffic
    for (int r = 0; r < 24; r++) begin
      i_digits     = 16'($urandom);
      i_raw_segs   = 28'($urandom);
      i_raw_mode   = 1'($urandom);
      i_dig_en     = 4'($urandom);
      i_dp         = 4'($urandom);
      i_brightness = 3'($urandom);
      repeat ($urandom_range(0, 40)) step();
      pulse_update();
      if (r % 8 == 7) begin
        repeat ($urandom_range(0, 20)) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end
    repeat (2 * FRAME) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
